// File: rtl/hyper_mem_emu_if.sv
// HyperBus pin bundle between a controller PHY (master) and the device emulator (slave).
// dq carries {rise byte, fall byte} per CK cycle; rwds likewise {rise, fall}.
interface hyper_mem_emu_if #(
    parameter int unsigned NumChips = 2
);
    logic [NumChips-1:0] cs_ni;
    logic [15:0]         dq_i;
    logic [1:0]          rwds_i;
    logic [15:0]         dq_o;
    logic                dq_oe_o;
    logic [1:0]          rwds_o;
    logic                rwds_oe_o;
    logic                busy_o;
    logic                err_o;

    modport slave (
        input  cs_ni, dq_i, rwds_i,
        output dq_o, dq_oe_o, rwds_o, rwds_oe_o, busy_o, err_o
    );

    modport master (
        output cs_ni, dq_i, rwds_i,
        input  dq_o, dq_oe_o, rwds_o, rwds_oe_o, busy_o, err_o
    );
endinterface

// File: rtl/hyper_mem_emu.sv
// Cycle-accurate HyperRAM device emulator, SDR-folded (one clk_i cycle = one CK period).
// Serves NumChips chip selects, each with its own DepthWords x 16 memory and CR0 register.
// Cycle n of a transaction is the clock edge n after CS first sampled low; registered
// outputs for cycle n appear right after that edge.
module hyper_mem_emu #(
    parameter int unsigned NumChips     = 2,
    parameter int unsigned DepthWords   = 1024,
    parameter int unsigned LatDefault   = 6,
    parameter logic        FixedDefault = 1'b1,
    parameter logic [15:0] IdReg        = 16'h0c81
) (
    input logic            clk_i,
    input logic            rst_i,
    hyper_mem_emu_if.slave bus
);
    localparam int unsigned AW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
    localparam int unsigned CW = (NumChips > 1) ? $clog2(NumChips) : 1;
    localparam logic [15:0] Cr0Reset = {8'h00, 4'(LatDefault), FixedDefault, 3'b000};

    // State names describe what the next clock edge consumes: IDLE takes CA beat 0,
    // CA1/CA2 take the remaining CA beats, LAT counts latency, WDATA/RDATA move data.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA1,
        ST_CA2,
        ST_LAT,
        ST_WDATA,
        ST_RDATA
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   chip_q, chip_d;
    logic            rd_q, rd_d;
    logic            as_q, as_d;
    logic            first_q, first_d;
    logic [28:0]     upper_q, upper_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [15:0]     cr0_q [NumChips];
    logic [15:0]     cr0_d [NumChips];
    logic [15:0]     dq_q, dq_d;
    logic            dq_oe_q, dq_oe_d;
    logic [1:0]      rwds_q, rwds_d;
    logic            rwds_oe_q, rwds_oe_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [1:0]      mem_we;

    logic [15:0]     mem [NumChips][DepthWords];

    logic [NumChips-1:0] cs_low;
    logic [NumChips-1:0] cur_mask;
    logic                cs_all_high;
    logic                cs_one_hot;
    logic [CW-1:0]       sel_chip;
    int unsigned         n_low;
    logic [3:0]          lat_field;
    logic [3:0]          lat_base;
    logic [4:0]          lat_eff;
    logic [31:0]         addr_full;

    // Decode chip selects and the latency of the chip currently addressed.
    always_comb begin
        cs_low   = ~bus.cs_ni;
        n_low    = 0;
        sel_chip = '0;
        for (int unsigned i = 0; i < NumChips; i++) begin
            if (cs_low[i]) begin
                n_low    = n_low + 1;
                sel_chip = CW'(i);
            end
        end
        cs_all_high = (n_low == 0);
        cs_one_hot  = (n_low == 1);
        cur_mask    = '0;
        cur_mask[chip_q] = 1'b1;

        lat_field = cr0_q[chip_q][7:4];
        lat_base  = (lat_field < 4'd3) ? 4'd3 : lat_field;
        lat_eff   = cr0_q[chip_q][3] ? {lat_base, 1'b0} : {1'b0, lat_base};
        addr_full = {upper_q, bus.dq_i[2:0]};
    end

    // Transaction sequencing, next-output computation and memory write enables.
    always_comb begin
        state_d   = state_q;
        chip_d    = chip_q;
        rd_d      = rd_q;
        as_d      = as_q;
        first_d   = first_q;
        upper_d   = upper_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        cr0_d     = cr0_q;
        dq_d      = '0;
        dq_oe_d   = 1'b0;
        rwds_d    = '0;
        rwds_oe_d = 1'b0;
        err_d     = 1'b0;
        mem_we    = '0;

        if (state_q == ST_IDLE) begin
            if (cs_one_hot) begin
                chip_d    = sel_chip;
                rd_d      = bus.dq_i[15];
                as_d      = bus.dq_i[14];
                upper_d   = {bus.dq_i[12:0], 16'h0000};
                rwds_oe_d = 1'b1;
                rwds_d    = {2{cr0_q[sel_chip][3]}};
                state_d   = ST_CA1;
            end else if (!cs_all_high) begin
                err_d = 1'b1;
            end
        end else if (cs_all_high) begin
            // Any CS rise ends the transaction; the beat presented on that edge is dropped.
            state_d = ST_IDLE;
            err_d   = (state_q == ST_CA1) || (state_q == ST_CA2) || (state_q == ST_LAT);
        end else if (cs_low != cur_mask) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_CA1: begin
                    upper_d   = {upper_q[28:16], bus.dq_i};
                    rwds_oe_d = 1'b1;
                    rwds_d    = rwds_q;
                    state_d   = ST_CA2;
                end
                ST_CA2: begin
                    addr_d    = AW'(addr_full);
                    rwds_oe_d = 1'b1;
                    rwds_d    = rwds_q;
                    if (!rd_q && as_q) begin
                        state_d = ST_WDATA;
                        first_d = 1'b1;
                    end else begin
                        state_d = ST_LAT;
                        cnt_d   = lat_eff - 5'd1;
                    end
                end
                ST_LAT: begin
                    if (cnt_q == '0) begin
                        state_d = rd_q ? ST_RDATA : ST_WDATA;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                ST_WDATA: begin
                    if (as_q) begin
                        if (first_q && (addr_q == '0)) begin
                            cr0_d[chip_q] = bus.dq_i;
                        end
                        first_d = 1'b0;
                    end else begin
                        mem_we = ~bus.rwds_i;
                        addr_d = addr_q + AW'(1);
                    end
                end
                ST_RDATA: begin
                    dq_oe_d   = 1'b1;
                    rwds_oe_d = 1'b1;
                    rwds_d    = 2'b10;
                    if (as_q) begin
                        dq_d = (addr_q == '0) ? cr0_q[chip_q] : IdReg;
                    end else begin
                        dq_d   = mem[chip_q][addr_q];
                        addr_d = addr_q + AW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, CR0 and output registers; async reset clears outputs immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            chip_q    <= '0;
            rd_q      <= 1'b0;
            as_q      <= 1'b0;
            first_q   <= 1'b0;
            upper_q   <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < NumChips; i++) begin
                cr0_q[i] <= Cr0Reset;
            end
            dq_q      <= '0;
            dq_oe_q   <= 1'b0;
            rwds_q    <= '0;
            rwds_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            chip_q    <= chip_d;
            rd_q      <= rd_d;
            as_q      <= as_d;
            first_q   <= first_d;
            upper_q   <= upper_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            cr0_q     <= cr0_d;
            dq_q      <= dq_d;
            dq_oe_q   <= dq_oe_d;
            rwds_q    <= rwds_d;
            rwds_oe_q <= rwds_oe_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // Byte-masked memory write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we[1]) mem[chip_q][addr_q][15:8] <= bus.dq_i[15:8];
        if (mem_we[0]) mem[chip_q][addr_q][7:0]  <= bus.dq_i[7:0];
    end

    assign bus.dq_o      = dq_q;
    assign bus.dq_oe_o   = dq_oe_q;
    assign bus.rwds_o    = rwds_q;
    assign bus.rwds_oe_o = rwds_oe_q;
    assign bus.busy_o    = busy_q;
    assign bus.err_o     = err_q;
endmodule

// File: tb/tb_hyper_mem_emu.sv
// Self-checking bench for hyper_mem_emu: directed scenarios plus randomized traffic,
// checked against a transaction-level model of memory, CR0 and bus timing.
module tb_hyper_mem_emu;
    localparam int NC = 2;
    localparam int D  = 1024;
    localparam logic [15:0] ID      = 16'h0c81;
    localparam logic [15:0] CR0_DEF = 16'h0068;

    logic clk = 1'b0;
    logic rst;
    int   vec  = 0;
    int   errs = 0;

    logic [15:0] mem_m [NC][D];
    logic [1:0]  vld_m [NC][D];
    logic [15:0] cr0_m [NC];

    always #5 clk = ~clk;

    hyper_mem_emu_if #(.NumChips(NC)) bus ();

    hyper_mem_emu #(
        .NumChips(NC),
        .DepthWords(D),
        .LatDefault(6),
        .FixedDefault(1'b1),
        .IdReg(ID)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_eff(input int chip);
        int l;
        l = int'(cr0_m[chip][7:4]);
        if (l < 3) l = 3;
        return cr0_m[chip][3] ? 2 * l : l;
    endfunction

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, bus.busy_o, 0);
        chk({tag, "_dq_oe"}, bus.dq_oe_o, 0);
        chk({tag, "_rwds_oe"}, bus.rwds_oe_o, 0);
    endtask

    // One HyperBus transaction. ncyc < 0: CS stays low through all beats, otherwise CS
    // is low for exactly ncyc cycles. rst_cyc >= 0 asserts reset just after that cycle.
    task automatic xfer(input int chip, input bit rd, input bit rs, input int addr,
                        input int nbeats, input logic [1:0] mask, input bit use_fix,
                        input logic [15:0] fixd, input int ncyc, input int rst_cyc);
        logic [47:0]   ca;
        logic [15:0]   wd;
        logic [NC-1:0] csv;
        logic [1:0]    flag;
        int first, stop, a;
        bit drv;
        ca    = {rd, rs, 1'b0, 29'(addr >> 3), 13'd0, 3'(addr)};
        flag  = cr0_m[chip][3] ? 2'b11 : 2'b00;
        first = (!rd && rs) ? 3 : 3 + lat_eff(chip);
        stop  = (ncyc >= 0) ? ncyc : first + nbeats;
        csv   = '1;
        csv[chip] = 1'b0;
        for (int n = 0; n < stop; n++) begin
            @(negedge clk);
            if (n == 0)      wd = ca[47:32];
            else if (n == 1) wd = ca[31:16];
            else if (n == 2) wd = ca[15:0];
            else             wd = use_fix ? fixd : 16'($urandom);
            bus.cs_ni  = csv;
            bus.dq_i   = wd;
            bus.rwds_i = mask;
            @(posedge clk);
            #1;
            drv = rd && (n >= first);
            chk("busy", bus.busy_o, 1);
            chk("err_mid", bus.err_o, 0);
            chk("dq_oe", bus.dq_oe_o, drv);
            chk("rwds_oe", bus.rwds_oe_o, (n <= 2) || drv);
            chk("rwds", bus.rwds_o, (n <= 2) ? flag : (drv ? 2'b10 : 2'b00));
            if (n >= first) begin
                a = (addr + n - first) % D;
                if (rd) begin
                    if (rs) chk("reg_rd", bus.dq_o, ((addr % D) == 0) ? cr0_m[chip] : ID);
                    else if (vld_m[chip][a] == 2'b11) chk("rd_data", bus.dq_o, mem_m[chip][a]);
                end else if (rs) begin
                    if (n == first && (addr % D) == 0) cr0_m[chip] = wd;
                end else begin
                    if (!mask[1]) begin mem_m[chip][a][15:8] = wd[15:8]; vld_m[chip][a][1] = 1'b1; end
                    if (!mask[0]) begin mem_m[chip][a][7:0]  = wd[7:0];  vld_m[chip][a][0] = 1'b1; end
                end
            end
            if (n == rst_cyc) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_dq_oe", bus.dq_oe_o, 0);
                chk("rst_rwds_oe", bus.rwds_oe_o, 0);
                chk("rst_busy", bus.busy_o, 0);
                chk("rst_dq", bus.dq_o, 0);
                for (int c = 0; c < NC; c++) cr0_m[c] = CR0_DEF;
                @(negedge clk);
                rst = 1'b0;
                bus.cs_ni = '1;
                @(posedge clk);
                #1;
                idle_chk("post_rst");
                return;
            end
        end
        @(negedge clk);
        bus.cs_ni = '1;
        bus.dq_i  = 16'($urandom);
        @(posedge clk);
        #1;
        chk("err_end", bus.err_o, stop < first);
        idle_chk("end");
    endtask

    initial begin
        int r, chip, rc;
        for (int c = 0; c < NC; c++) begin
            cr0_m[c] = CR0_DEF;
            for (int w = 0; w < D; w++) vld_m[c][w] = 2'b00;
        end
        rst        = 1'b1;
        bus.cs_ni  = '1;
        bus.dq_i   = '0;
        bus.rwds_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dq", bus.dq_o, 0);
        chk("reset_dq_oe", bus.dq_oe_o, 0);
        chk("reset_rwds", bus.rwds_o, 0);
        chk("reset_rwds_oe", bus.rwds_oe_o, 0);
        chk("reset_busy", bus.busy_o, 0);
        chk("reset_err", bus.err_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed 2x latency write then read back, data at cycle 15.
        xfer(0, 0, 0, 'h10, 4, 2'b00, 1, 16'hA5A5, -1, -1);
        xfer(0, 1, 0, 'h10, 4, 2'b00, 0, 16'h0, -1, -1);

        // CR0 = L3 variable on chip1, then wrapping write/read from 0x3FF.
        xfer(1, 0, 1, 0, 1, 2'b00, 1, 16'h0030, -1, -1);
        xfer(1, 0, 0, 'h3FF, 3, 2'b00, 0, 16'h0, -1, -1);
        xfer(1, 1, 0, 'h3FF, 3, 2'b00, 0, 16'h0, -1, -1);

        // Byte-masked write over a preloaded word (address folds mod depth).
        xfer(0, 0, 0, 'h1234, 1, 2'b00, 1, 16'hFFFF, -1, -1);
        xfer(0, 0, 0, 'h1234, 1, 2'b01, 1, 16'hABCD, -1, -1);
        xfer(0, 1, 0, 'h1234, 1, 2'b00, 0, 16'h0, -1, -1);

        // Two chip selects low in idle.
        @(negedge clk);
        bus.cs_ni = 2'b00;
        bus.dq_i  = 16'h4000;
        @(posedge clk);
        #1;
        chk("multi_cs_err", bus.err_o, 1);
        idle_chk("multi_cs");
        @(negedge clk);
        bus.cs_ni = '1;
        @(posedge clk);
        #1;
        chk("multi_cs_err_clr", bus.err_o, 0);
        xfer(1, 1, 1, 0, 2, 2'b00, 0, 16'h0, -1, -1);
        xfer(1, 1, 1, 5, 1, 2'b00, 0, 16'h0, -1, -1);

        // CS rise during latency of a 2x read.
        xfer(0, 1, 0, 'h10, 4, 2'b00, 0, 16'h0, 5, -1);

        // Randomized traffic over a preloaded window.
        for (int c = 0; c < NC; c++) xfer(c, 0, 0, 'h100, 16, 2'b00, 0, 16'h0, -1, -1);
        for (int t = 0; t < 30; t++) begin
            r    = $urandom_range(0, 9);
            chip = $urandom_range(0, NC - 1);
            case (r)
                0: xfer(chip, 0, 1, $urandom_range(0, 1), 2, 2'b00, 0, 16'h0, -1, -1);
                1: xfer(chip, 1, 1, $urandom_range(0, 3), 2, 2'b00, 0, 16'h0, -1, -1);
                2: xfer(chip, 0, 0, 'h100 + $urandom_range(0, 15), 4, 2'($urandom), 0, 16'h0,
                        $urandom_range(1, 24), -1);
                3, 4, 5: xfer(chip, 0, 0, 'h100 + $urandom_range(0, 15), $urandom_range(1, 6),
                              2'($urandom), 0, 16'h0, -1, -1);
                default: xfer(chip, 1, 0, 'h100 + $urandom_range(0, 15), $urandom_range(1, 6),
                              2'b00, 0, 16'h0, -1, -1);
            endcase
        end

        // Reset during read beat 2: earlier data kept, CR0 back to default.
        xfer(0, 0, 0, 'h40, 4, 2'b00, 0, 16'h0, -1, -1);
        rc = 3 + lat_eff(0) + 2;
        xfer(0, 1, 0, 'h40, 4, 2'b00, 0, 16'h0, -1, rc);
        xfer(0, 1, 0, 'h40, 4, 2'b00, 0, 16'h0, -1, -1);
        xfer(1, 1, 1, 0, 1, 2'b00, 0, 16'h0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
